ball_motion: RTL and testbench

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/pong_pkg.sv | 29 ++
 rtl/ball_axis_step.sv | 26 ++
 rtl/ball_motion.sv | 122 ++++++++++++
 tb/tb_ball_motion.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared game-state encoding, field geometry and ball FSM state type
package pong_pkg;

   localparam logic [1:0] GS_IDLE  = 2'd0;
   localparam logic [1:0] GS_SERVE = 2'd1;
   localparam logic [1:0] GS_PLAY  = 2'd2;
   localparam logic [1:0] GS_OVER  = 2'd3;

   localparam int FIELD_UP_Y       = 140;
   localparam int FIELD_DOWN_Y     = 340;
   localparam int FIELD_LEFT_GOAL  = 120;
   localparam int FIELD_RIGHT_GOAL = 520;
   localparam int FIELD_CENTER_X   = 320;
   localparam int FIELD_CENTER_Y   = 240;
   localparam int PADDLE_L_X       = 130;
   localparam int PADDLE_R_X       = 510;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SERVE,
      ST_MOVE,
      ST_SCORED
   } ball_state_t;

   function automatic logic signed [10:0] sext(input logic [9:0] v);
      return {v[9], v};
   endfunction

endpackage

// File: rtl/ball_axis_step.sv
// ball_axis_step: one axis position + signed speed, with edge flags and optional clamp
module ball_axis_step
   import pong_pkg::*;
#(
   parameter int LO    = 0,
   parameter int HI    = 639,
   parameter bit CLAMP = 1'b0
) (
   input  logic [9:0] pos,
   input  logic [9:0] speed,
   output logic [9:0] pos_next,
   output logic       at_lo,
   output logic       at_hi
);

   localparam logic signed [10:0] LO_S = 11'(LO);
   localparam logic signed [10:0] HI_S = 11'(HI);

   logic signed [10:0] sum;

   assign sum      = $signed({1'b0, pos}) + sext(speed);
   assign at_lo    = sum <= LO_S;
   assign at_hi    = sum >= HI_S;
   assign pos_next = (CLAMP && at_lo) ? LO_S[9:0] : (CLAMP && at_hi) ? HI_S[9:0] : sum[9:0];

endmodule

// File: rtl/ball_motion.sv
// ball_motion: ball position/speed state machine with serve, wall clamp and goal scoring
module ball_motion
   import pong_pkg::*;
#(
   parameter int UP_Y       = FIELD_UP_Y,
   parameter int DOWN_Y     = FIELD_DOWN_Y,
   parameter int LEFT_GOAL  = FIELD_LEFT_GOAL,
   parameter int RIGHT_GOAL = FIELD_RIGHT_GOAL,
   parameter int CENTER_X   = FIELD_CENTER_X,
   parameter int CENTER_Y   = FIELD_CENTER_Y,
   parameter int SERVE_SX   = 2,
   parameter int SERVE_SY   = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [1:0] game_state,
   input  logic [9:0] next_speed_x,
   input  logic [9:0] next_speed_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] now_speed_x,
   output logic [9:0] now_speed_y,
   output logic       p1_point,
   output logic       p2_point,
   output logic       ball_active
);

   localparam logic [9:0] CX     = 10'(CENTER_X);
   localparam logic [9:0] CY     = 10'(CENTER_Y);
   localparam logic [9:0] SX_POS = 10'(SERVE_SX);
   localparam logic [9:0] SX_NEG = 10'(-SERVE_SX);
   localparam logic [9:0] SY     = 10'(SERVE_SY);

   ball_state_t state;
   logic        serve_dir;
   logic [9:0]  x_next, y_next;
   logic        x_lo, x_hi, y_lo, y_hi;
   logic        unused_y_flags;

   ball_axis_step #(.LO(LEFT_GOAL), .HI(RIGHT_GOAL), .CLAMP(1'b0)) u_x (
      .pos(ball_x), .speed(next_speed_x), .pos_next(x_next), .at_lo(x_lo), .at_hi(x_hi)
   );

   ball_axis_step #(.LO(UP_Y), .HI(DOWN_Y), .CLAMP(1'b1)) u_y (
      .pos(ball_y), .speed(next_speed_y), .pos_next(y_next), .at_lo(y_lo), .at_hi(y_hi)
   );

   assign unused_y_flags = y_lo ^ y_hi;

   // ball FSM: reset, then idle/over abort, then per-state serve, move and score handling
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         ball_x      <= CX;
         ball_y      <= CY;
         now_speed_x <= '0;
         now_speed_y <= '0;
         p1_point    <= 1'b0;
         p2_point    <= 1'b0;
         ball_active <= 1'b0;
         serve_dir   <= 1'b0;
      end else begin
         p1_point <= 1'b0;
         p2_point <= 1'b0;
         if (game_state == GS_IDLE || game_state == GS_OVER) begin
            state       <= ST_IDLE;
            ball_x      <= CX;
            ball_y      <= CY;
            now_speed_x <= '0;
            now_speed_y <= '0;
            ball_active <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (game_state == GS_SERVE) begin
                  state       <= ST_SERVE;
                  ball_x      <= CX;
                  ball_y      <= CY;
                  now_speed_x <= serve_dir ? SX_NEG : SX_POS;
                  now_speed_y <= SY;
               end
               ST_SERVE: if (frame_tick && game_state == GS_PLAY) begin
                  state       <= ST_MOVE;
                  ball_active <= 1'b1;
               end
               ST_MOVE: if (game_state != GS_PLAY) begin
                  state       <= ST_SERVE;
                  ball_active <= 1'b0;
                  ball_x      <= CX;
                  ball_y      <= CY;
                  now_speed_x <= serve_dir ? SX_NEG : SX_POS;
                  now_speed_y <= SY;
               end else if (frame_tick) begin
                  ball_x <= x_next;
                  ball_y <= y_next;
                  if (x_lo || x_hi) begin
                     state       <= ST_SCORED;
                     ball_active <= 1'b0;
                     now_speed_x <= '0;
                     now_speed_y <= '0;
                     p2_point    <= x_lo;
                     p1_point    <= !x_lo;
                     serve_dir   <= !x_lo;
                  end else begin
                     now_speed_x <= next_speed_x;
                     now_speed_y <= next_speed_y;
                  end
               end
               ST_SCORED: if (frame_tick) begin
                  state       <= ST_SERVE;
                  ball_x      <= CX;
                  ball_y      <= CY;
                  now_speed_x <= serve_dir ? SX_NEG : SX_POS;
                  now_speed_y <= SY;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: table-driven directed checks of serve, move, clamp, scoring and aborts
module tb_ball_motion;

   typedef struct {
      logic       rst_n;
      logic       tick;
      logic [1:0] gs;
      logic [9:0] nsx, nsy, ex, ey, esx, esy;
      logic       ep1, ep2, eact;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic [1:0] game_state = 2'd0;
   logic [9:0] next_speed_x = '0, next_speed_y = '0;
   logic [9:0] ball_x, ball_y, now_speed_x, now_speed_y;
   logic       p1_point, p2_point, ball_active;

   int checks = 0;
   int errors = 0;
   int p1_cnt = 0;
   int p2_cnt = 0;
   vec_t q[$];

   ball_motion dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_state(game_state),
      .next_speed_x(next_speed_x), .next_speed_y(next_speed_y),
      .ball_x(ball_x), .ball_y(ball_y), .now_speed_x(now_speed_x), .now_speed_y(now_speed_y),
      .p1_point(p1_point), .p2_point(p2_point), .ball_active(ball_active)
   );

   always #5 clk = ~clk;

   // tally score pulses over the whole run
   always @(negedge clk) begin
      if (p1_point === 1'b1) p1_cnt++;
      if (p2_point === 1'b1) p2_cnt++;
   end

   function automatic vec_t mk(input logic r, t, input logic [1:0] g,
                               input logic [9:0] nx, ny, x, y, sx, sy,
                               input logic p1, p2, act);
      vec_t v;
      v.rst_n = r; v.tick = t; v.gs = g; v.nsx = nx; v.nsy = ny;
      v.ex = x; v.ey = y; v.esx = sx; v.esy = sy; v.ep1 = p1; v.ep2 = p2; v.eact = act;
      return v;
   endfunction

   task automatic check(input string name, input logic [42:0] got, input logic [42:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got x=%0d y=%0d sx=%h sy=%h p1=%b p2=%b act=%b expected x=%0d y=%0d sx=%h sy=%h p1=%b p2=%b act=%b",
                  name, got[42:33], got[32:23], got[22:13], got[12:3], got[2], got[1], got[0],
                  exp[42:33], exp[32:23], exp[22:13], exp[12:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      int n;
      // reset, idle, serve 0->1->2
      q.push_back(mk(0,0,0, 10'd0,   10'd0,   10'd320,10'd240,10'h000,10'h000,0,0,0));
      q.push_back(mk(1,0,0, 10'd0,   10'd0,   10'd320,10'd240,10'h000,10'h000,0,0,0));
      q.push_back(mk(1,0,1, 10'd0,   10'd0,   10'd320,10'd240,10'h002,10'h001,0,0,0));
      q.push_back(mk(1,0,2, 10'd0,   10'd0,   10'd320,10'd240,10'h002,10'h001,0,0,0));
      q.push_back(mk(1,1,2, 10'd9,   10'd9,   10'd320,10'd240,10'h002,10'h001,0,0,1));
      q.push_back(mk(1,1,2, 10'd2,   10'd1,   10'd322,10'd241,10'h002,10'h001,0,0,1));
      q.push_back(mk(1,0,2, 10'd5,   10'd5,   10'd322,10'd241,10'h002,10'h001,0,0,1));
      // bottom clamp, speed kept
      q.push_back(mk(1,1,2, 10'd0,   10'd63,  10'd322,10'd304,10'h000,10'h03F,0,0,1));
      q.push_back(mk(1,1,2, 10'd0,   10'd34,  10'd322,10'd338,10'h000,10'h022,0,0,1));
      q.push_back(mk(1,1,2, 10'd0,   10'd5,   10'd322,10'd340,10'h000,10'h005,0,0,1));
      // top clamp
      q.push_back(mk(1,1,2, 10'd0,   10'h3C1, 10'd322,10'd277,10'h000,10'h3C1,0,0,1));
      q.push_back(mk(1,1,2, 10'd0,   10'h3C1, 10'd322,10'd214,10'h000,10'h3C1,0,0,1));
      q.push_back(mk(1,1,2, 10'd0,   10'h3C1, 10'd322,10'd151,10'h000,10'h3C1,0,0,1));
      q.push_back(mk(1,1,2, 10'd0,   10'h3F0, 10'd322,10'd140,10'h000,10'h3F0,0,0,1));
      // left goal
      q.push_back(mk(1,1,2, 10'h3C1, 10'd0,   10'd259,10'd140,10'h3C1,10'h000,0,0,1));
      q.push_back(mk(1,1,2, 10'h3C1, 10'd0,   10'd196,10'd140,10'h3C1,10'h000,0,0,1));
      q.push_back(mk(1,1,2, 10'h3C1, 10'd0,   10'd133,10'd140,10'h3C1,10'h000,0,0,1));
      q.push_back(mk(1,1,2, 10'h3F6, 10'd0,   10'd123,10'd140,10'h3F6,10'h000,0,0,1));
      q.push_back(mk(1,1,2, 10'h3FC, 10'd0,   10'd119,10'd140,10'h000,10'h000,0,1,0));
      q.push_back(mk(1,0,2, 10'h3FC, 10'd0,   10'd119,10'd140,10'h000,10'h000,0,0,0));
      q.push_back(mk(1,1,2, 10'd0,   10'd0,   10'd320,10'd240,10'h002,10'h001,0,0,0));
      q.push_back(mk(1,1,2, 10'd3,   10'd3,   10'd320,10'd240,10'h002,10'h001,0,0,1));
      // game over coincident with tick
      q.push_back(mk(1,1,3, 10'd5,   10'd5,   10'd320,10'd240,10'h000,10'h000,0,0,0));
      q.push_back(mk(1,0,3, 10'd5,   10'd5,   10'd320,10'd240,10'h000,10'h000,0,0,0));
      // right goal
      q.push_back(mk(1,0,1, 10'd0,   10'd0,   10'd320,10'd240,10'h002,10'h001,0,0,0));
      q.push_back(mk(1,1,2, 10'd0,   10'd0,   10'd320,10'd240,10'h002,10'h001,0,0,1));
      q.push_back(mk(1,1,2, 10'd63,  10'd0,   10'd383,10'd240,10'h03F,10'h000,0,0,1));
      q.push_back(mk(1,1,2, 10'd63,  10'd0,   10'd446,10'd240,10'h03F,10'h000,0,0,1));
      q.push_back(mk(1,1,2, 10'd63,  10'd0,   10'd509,10'd240,10'h03F,10'h000,0,0,1));
      q.push_back(mk(1,1,2, 10'd8,   10'd0,   10'd517,10'd240,10'h008,10'h000,0,0,1));
      q.push_back(mk(1,1,2, 10'd3,   10'd0,   10'd520,10'd240,10'h000,10'h000,1,0,0));
      q.push_back(mk(1,0,2, 10'd3,   10'd0,   10'd520,10'd240,10'h000,10'h000,0,0,0));
      q.push_back(mk(1,1,1, 10'd0,   10'd0,   10'd320,10'd240,10'h3FE,10'h001,0,0,0));
      // reset mid-rally at (400,200)
      q.push_back(mk(1,1,2, 10'd0,   10'd0,   10'd320,10'd240,10'h3FE,10'h001,0,0,1));
      q.push_back(mk(1,1,2, 10'd63,  10'h3C1, 10'd383,10'd177,10'h03F,10'h3C1,0,0,1));
      q.push_back(mk(1,1,2, 10'd17,  10'd23,  10'd400,10'd200,10'h011,10'h017,0,0,1));
      q.push_back(mk(0,1,2, 10'd2,   10'd0,   10'd320,10'd240,10'h000,10'h000,0,0,0));
      q.push_back(mk(1,0,1, 10'd2,   10'd0,   10'd320,10'd240,10'h002,10'h001,0,0,0));
      // leaving play while moving, coincident tick
      q.push_back(mk(1,1,2, 10'd0,   10'd0,   10'd320,10'd240,10'h002,10'h001,0,0,1));
      q.push_back(mk(1,1,1, 10'd5,   10'd5,   10'd320,10'd240,10'h002,10'h001,0,0,0));

      foreach (q[i]) begin
         reset = q[i].rst_n; frame_tick = q[i].tick; game_state = q[i].gs;
         next_speed_x = q[i].nsx; next_speed_y = q[i].nsy;
         @(posedge clk); #1;
         check($sformatf("row%0d", i),
               {ball_x, ball_y, now_speed_x, now_speed_y, p1_point, p2_point, ball_active},
               {q[i].ex, q[i].ey, q[i].esx, q[i].esy, q[i].ep1, q[i].ep2, q[i].eact});
      end

      // rally to the right goal with a bounded wait for the point pulse
      reset = 1; game_state = 2; frame_tick = 1; next_speed_x = 10'd63; next_speed_y = 10'd0;
      @(posedge clk); #1;
      n = 0;
      while (n < 8 && p1_point !== 1'b1) begin
         @(posedge clk); #1;
         n++;
      end
      check_int("p1_ticks", n, 4);
      check_int("p1_x", int'(ball_x), 572);
      frame_tick = 0;
      @(posedge clk); #1;
      check_int("p1_single_pulse", int'(p1_point), 0);
      check_int("p1_total", p1_cnt, 2);
      check_int("p2_total", p2_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
